// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: applies a 2-bit shift op (none/LSL/LSR/ASR) one position per cycle.
// Optional ITER_SHIFT_FAST_EN: two positions per cycle while at least two remain.
module iter_shift_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [CNT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [1:0]       OpNone = 2'b00;
  localparam logic [1:0]       OpLsl  = 2'b01;
  localparam logic [1:0]       OpLsr  = 2'b10;
  localparam logic [1:0]       OpAsr  = 2'b11;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q;
  logic [WIDTH-1:0] sout_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  // ASR replicates the current MSB, so the sign persists across iterations.
  function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v;
    case (op)
      OpLsl:   r = {v[WIDTH-2:0], 1'b0};
      OpLsr:   r = {1'b0, v[WIDTH-1:1]};
      OpAsr:   r = {v[WIDTH-1], v[WIDTH-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef ITER_SHIFT_FAST_EN
  localparam logic [CNT_W-1:0] CntTwo = CNT_W'(2);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sout_q  <= '0;
      op_q    <= OpNone;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            sout_q  <= in;
            op_q    <= shift;
            cnt_q   <= amount;
            state_q <= (shift == OpNone || amount == '0) ? StDone : StShift;
          end
        end
        StShift: begin
`ifdef ITER_SHIFT_FAST_EN
          if (cnt_q >= CntTwo) begin
            sout_q <= shift_one(op_q, shift_one(op_q, sout_q));
            cnt_q  <= cnt_q - CntTwo;
            if (cnt_q == CntTwo) state_q <= StDone;
          end else begin
            sout_q  <= shift_one(op_q, sout_q);
            cnt_q   <= cnt_q - CntOne;
            state_q <= StDone;
          end
`else
          sout_q <= shift_one(op_q, sout_q);
          cnt_q  <= cnt_q - CntOne;
          if (cnt_q == CntOne) state_q <= StDone;
`endif
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sout = sout_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Self-checking bench for iter_shift_unit: directed vector table, corner sequences and
// random operations checked against an arithmetic shift model.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] in_s = '0;
  logic [1:0]  shift_s = '0;
  logic [3:0]  amount_s = '0;
  logic        busy;
  logic        done;
  logic [15:0] sout;

  int total = 0;
  int bad = 0;

  iter_shift_unit #(.WIDTH(16), .CNT_W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .in     (in_s),
    .shift  (shift_s),
    .amount (amount_s),
    .busy   (busy),
    .done   (done),
    .sout   (sout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [1:0]  sh;
    logic [3:0]  amt;
    logic [15:0] exp;
    bit          mid;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [15:0] model_sout(input logic [15:0] d, input logic [1:0] sh,
                                             input logic [3:0] amt);
    logic signed [15:0] s;
    logic [15:0] r;
    s = d;
    case (sh)
      2'b01:   r = d << amt;
      2'b10:   r = d >> amt;
      2'b11:   r = s >>> amt;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] sh, input logic [3:0] amt);
    if (sh == 2'b00 || amt == 4'd0) return 0;
`ifdef ITER_SHIFT_FAST_EN
    return (int'(amt) + 1) / 2;
`else
    return int'(amt);
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One operation: start, optional stray start mid-op, measure latency/busy, check result.
  task automatic run_op(input string name, input logic [15:0] d, input logic [1:0] sh,
                        input logic [3:0] amt, input logic [15:0] exp, input bit mid);
    int  lat_exp;
    int  k;
    int  busy_n;
    bit  seen;
    lat_exp = model_lat(sh, amt);
    @(negedge clk);
    in_s = d; shift_s = sh; amount_s = amt; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_s = 16'($urandom); shift_s = 2'($urandom); amount_s = 4'($urandom);
    seen = 1'b0; busy_n = 0; k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        if (mid && k == 1 && busy) begin
          start = 1'b1; in_s = 16'h1234; shift_s = 2'b01; amount_s = 4'd2;
        end else start = 1'b0;
        k++;
      end
    end
    start = 1'b0;
    chk({name, " latency"}, 32'(k), 32'(lat_exp));
    chk({name, " busy cycles"}, 32'(busy_n), 32'(lat_exp + 1));
    chk({name, " sout"}, 32'(sout), 32'(exp));
    @(negedge clk);
    chk({name, " done pulse end"}, {30'd0, done, busy}, 32'd0);
    chk({name, " sout held"}, 32'(sout), 32'(exp));
  endtask

  initial begin
    int dn;
    logic [15:0] d;
    logic [1:0]  sh;
    logic [3:0]  amt;

    vecs[0] = '{16'hF0CF, 2'b01, 4'd1,  16'hE19E, 1'b0};
    vecs[1] = '{16'hF0CF, 2'b10, 4'd4,  16'h0F0C, 1'b0};
    vecs[2] = '{16'hF0CF, 2'b11, 4'd4,  16'hFF0C, 1'b0};
    vecs[3] = '{16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0};
    vecs[4] = '{16'hF0CF, 2'b00, 4'd7,  16'hF0CF, 1'b0};
    vecs[5] = '{16'hF0CF, 2'b01, 4'd0,  16'hF0CF, 1'b0};
    vecs[6] = '{16'hF0CF, 2'b01, 4'd15, 16'h8000, 1'b1};
    vecs[7] = '{16'hF0CF, 2'b10, 4'd5,  16'h0786, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {14'd0, busy, done, sout}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].din, vecs[i].sh, vecs[i].amt, vecs[i].exp,
             vecs[i].mid);

    // start held high: accepted at E0, ignored in DONE, accepted again in the next IDLE.
    @(negedge clk);
    in_s = 16'hAAAA; shift_s = 2'b00; amount_s = 4'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("held start first done", {30'd0, busy, done}, 32'd3);
    @(negedge clk);
    chk("held start idle gap", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("held start re-accept", {30'd0, busy, done}, 32'd3);
    start = 1'b0;
    @(negedge clk);
    chk("held start sout", 32'(sout), 32'h0000AAAA);

    // Reset two cycles into a long LSR discards the operation.
    @(negedge clk);
    in_s = 16'hF0CF; shift_s = 2'b10; amount_s = 4'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid-op reset", {14'd0, busy, done, sout}, 32'd0);
    reset = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("no done after reset", 32'(dn), 32'd0);

    for (int i = 0; i < 60; i++) begin
      d = 16'($urandom);
      sh = 2'($urandom);
      amt = 4'($urandom_range(0, 15));
      run_op($sformatf("rand%0d", i), d, sh, amt, model_sout(d, sh, amt), (i % 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
